// File: rtl/m_trap_unit_pkg.sv
// Shared machine-mode privileged definitions for the Lagarto Hun trap unit:
// CSR command encoding, cause codes, interrupt bit positions, CSR addresses.
package m_trap_unit_pkg;

  typedef enum logic [2:0] {
    CSR_NONE           = 3'd0,
    CSR_READ_ONLY      = 3'd1,
    CSR_WRITE_AND_READ = 3'd2,
    CSR_SET_AND_READ   = 3'd3,
    CSR_CLEAR_AND_READ = 3'd4
  } csr_command_t;

  // Interrupt cause codes (mcause with the interrupt bit set).
  typedef enum logic [5:0] {
    IRQ_M_SOFTWARE = 6'd3,
    IRQ_M_TIMER    = 6'd7,
    IRQ_M_EXTERNAL = 6'd11
  } irq_code_t;

  // Synchronous exception cause codes (mcause with the interrupt bit clear).
  typedef enum logic [5:0] {
    EXC_INSTR_MISALIGNED = 6'd0,
    EXC_INSTR_FAULT      = 6'd1,
    EXC_ILLEGAL_INSTR    = 6'd2,
    EXC_BREAKPOINT       = 6'd3,
    EXC_LOAD_MISALIGNED  = 6'd4,
    EXC_LOAD_FAULT       = 6'd5,
    EXC_STORE_MISALIGNED = 6'd6,
    EXC_STORE_FAULT      = 6'd7,
    EXC_ECALL_M          = 6'd11
  } exc_code_t;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_WFI      = 2'd2
  } trap_state_t;

  // mip/mie bit positions.
  localparam int unsigned MIP_MSIP      = 3;
  localparam int unsigned MIP_MTIP      = 7;
  localparam int unsigned MIP_MEIP      = 11;
  localparam int unsigned MIP_LOCAL_LSB = 16;

  // mstatus bit positions.
  localparam int unsigned MSTATUS_MIE     = 3;
  localparam int unsigned MSTATUS_MPIE    = 7;
  localparam int unsigned MSTATUS_MPP_LSB = 11;

  localparam int unsigned MISA_I_BIT = 8;

  // Writable standard mie bits (MEIE, MTIE, MSIE); local bits are added per instance.
  localparam logic [63:0] MIE_STD_WMASK = 64'h0000_0000_0000_0888;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

endpackage

// File: rtl/m_trap_unit_if.sv
// CSR access bus and fetch redirect handshake between the core and the trap unit.
interface m_trap_unit_if
  import m_trap_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) ();

  logic [11:0]     csr_address_i;
  csr_command_t    csr_command_i;
  logic [XLEN-1:0] csr_write_data_i;
  logic [XLEN-1:0] csr_read_data_o;
  logic            csr_read_data_valid_o;
  logic            csr_illegal_o;

  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;

  modport master (
    output csr_address_i, csr_command_i, csr_write_data_i, redirect_ready_i,
    input  csr_read_data_o, csr_read_data_valid_o, csr_illegal_o,
           redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  csr_address_i, csr_command_i, csr_write_data_i, redirect_ready_i,
    output csr_read_data_o, csr_read_data_valid_o, csr_illegal_o,
           redirect_valid_o, redirect_pc_o
  );

endinterface

// File: rtl/m_trap_unit_irq_arbiter.sv
// Fixed-priority interrupt pick: MEI > MSI > MTI > local (lowest index first).
module irq_arbiter
  import m_trap_unit_pkg::*;
#(
  parameter int unsigned NUM_LOCAL_IRQ = 16
) (
  input  logic                     mei_pending,
  input  logic                     msi_pending,
  input  logic                     mti_pending,
  input  logic [NUM_LOCAL_IRQ-1:0] local_pending,
  output logic                     take,
  output logic [5:0]               code
);

  // Lowest priority is evaluated first so higher-priority sources override it.
  always_comb begin
    take = 1'b0;
    code = '0;
    for (int unsigned i = NUM_LOCAL_IRQ; i > 0; i--) begin
      if (local_pending[i-1]) begin
        take = 1'b1;
        code = 6'(MIP_LOCAL_LSB + i - 1);
      end
    end
    if (mti_pending) begin
      take = 1'b1;
      code = IRQ_M_TIMER;
    end
    if (msi_pending) begin
      take = 1'b1;
      code = IRQ_M_SOFTWARE;
    end
    if (mei_pending) begin
      take = 1'b1;
      code = IRQ_M_EXTERNAL;
    end
  end

endmodule

// File: rtl/m_trap_unit.sv
// Machine-mode CSR file and trap sequencer: owns the M-mode trap CSRs,
// arbitrates exceptions, interrupts, MRET and WFI, and redirects fetch.
module m_trap_unit
  import m_trap_unit_pkg::*;
#(
  parameter int unsigned     XLEN          = 64,
  parameter int unsigned     NUM_LOCAL_IRQ = 16,
  parameter logic [XLEN-1:0] BOOT_ADDRESS  = XLEN'(64'h8000_0000),
  parameter bit              VECTORED_EN   = 1'b1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  m_trap_unit_if.slave             bus,
  input  logic                     exception_i,
  input  logic [5:0]               exception_cause_i,
  input  logic [XLEN-1:0]          exception_pc_i,
  input  logic [XLEN-1:0]          exception_tval_i,
  input  logic                     mret_i,
  input  logic                     wfi_i,
  input  logic                     irq_external_i,
  input  logic                     irq_timer_i,
  input  logic                     irq_software_i,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
  input  logic [XLEN-1:0]          retire_pc_i,
  output logic                     busy_o
);

  localparam logic [XLEN-1:0] LOCAL_MASK =
    {{(XLEN-NUM_LOCAL_IRQ){1'b0}}, {NUM_LOCAL_IRQ{1'b1}}} << MIP_LOCAL_LSB;
  localparam logic [XLEN-1:0] MIE_WMASK  = XLEN'(MIE_STD_WMASK) | LOCAL_MASK;
  localparam logic [XLEN-1:0] MISA_VALUE =
    {2'b10, {(XLEN-2){1'b0}}} | (XLEN'(1) << MISA_I_BIT);

  trap_state_t     state_q, state_d;

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mip_q, mip_d;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [31:0]     mcounteren_q;
  logic [XLEN-3:0] mtvec_base_q;
  mtvec_mode_t     mtvec_mode_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus_rd, pending;
  logic            arb_take;
  logic [5:0]      arb_code;
  logic            in_idle, irq_ready;
  logic            take_exc, take_irq, take_mret, take_wfi, event_any;
  logic [XLEN-1:0] csr_old, csr_new, trap_base, trap_pc;
  logic            csr_known, csr_ro, csr_wr_cmd, csr_live, csr_reject, csr_we;

  assign pending = mip_q & mie_q;

  irq_arbiter #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
  ) u_irq_arbiter (
    .mei_pending   (pending[MIP_MEIP]),
    .msi_pending   (pending[MIP_MSIP]),
    .mti_pending   (pending[MIP_MTIP]),
    .local_pending (pending[MIP_LOCAL_LSB +: NUM_LOCAL_IRQ]),
    .take          (arb_take),
    .code          (arb_code)
  );

  // Raw interrupt levels, registered into mip next cycle.
  always_comb begin
    mip_d = '0;
    mip_d[MIP_MEIP] = irq_external_i;
    mip_d[MIP_MTIP] = irq_timer_i;
    mip_d[MIP_MSIP] = irq_software_i;
    mip_d[MIP_LOCAL_LSB +: NUM_LOCAL_IRQ] = irq_local_i;
  end

  // Event arbitration: exception > interrupt > mret > wfi > CSR write.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    irq_ready = mstatus_mie_q & arb_take;
    take_exc  = in_idle & exception_i;
    take_irq  = in_idle & ~exception_i & irq_ready;
    take_mret = in_idle & ~exception_i & ~irq_ready & mret_i;
    take_wfi  = in_idle & ~exception_i & ~irq_ready & ~mret_i & wfi_i;
    event_any = take_exc | take_irq | take_mret | take_wfi;
  end

  // CSR read mux and address legality.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MPP_LSB +: 2] = 2'b11;
    csr_old   = '0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (bus.csr_address_i)
      CSR_MSTATUS:    csr_old = mstatus_rd;
      CSR_MISA:       begin csr_old = MISA_VALUE; csr_ro = 1'b1; end
      CSR_MIE:        csr_old = mie_q;
      CSR_MTVEC:      csr_old = {mtvec_base_q, mtvec_mode_q};
      CSR_MCOUNTEREN: csr_old = XLEN'(mcounteren_q);
      CSR_MSCRATCH:   csr_old = mscratch_q;
      CSR_MEPC:       csr_old = mepc_q;
      CSR_MCAUSE:     csr_old = mcause_q;
      CSR_MTVAL:      csr_old = mtval_q;
      CSR_MIP:        csr_old = mip_q;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: csr_ro = 1'b1;
      default:        csr_known = 1'b0;
    endcase
  end

  // CSR command decode and write-value formation; accesses only land in IDLE with no event.
  always_comb begin
    csr_wr_cmd = (bus.csr_command_i == CSR_WRITE_AND_READ) ||
                 (bus.csr_command_i == CSR_SET_AND_READ) ||
                 (bus.csr_command_i == CSR_CLEAR_AND_READ);
    csr_live   = in_idle & ~event_any & (bus.csr_command_i != CSR_NONE);
    csr_reject = ~csr_known | (csr_wr_cmd & csr_ro);
    csr_we     = csr_live & ~csr_reject & csr_wr_cmd;
    case (bus.csr_command_i)
      CSR_WRITE_AND_READ: csr_new = bus.csr_write_data_i;
      CSR_SET_AND_READ:   csr_new = csr_old | bus.csr_write_data_i;
      CSR_CLEAR_AND_READ: csr_new = csr_old & ~bus.csr_write_data_i;
      default:            csr_new = csr_old;
    endcase
    bus.csr_illegal_o         = csr_live & csr_reject;
    bus.csr_read_data_valid_o = csr_live & ~csr_reject;
    bus.csr_read_data_o       = (csr_live & ~csr_reject) ? csr_old : '0;
  end

  // Trap vector: base, plus 4*code for interrupts in vectored mode.
  always_comb begin
    trap_base = {mtvec_base_q, 2'b00};
    trap_pc   = trap_base;
    if (take_irq && mtvec_mode_q == MTVEC_VECTORED)
      trap_pc = trap_base + XLEN'({arb_code, 2'b00});
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exc || take_irq || take_mret) state_d = ST_REDIRECT;
        else if (take_wfi)                     state_d = ST_WFI;
      end
      ST_REDIRECT: if (bus.redirect_ready_i) state_d = ST_IDLE;
      ST_WFI:      if (|pending)             state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.redirect_valid_o = (state_q == ST_REDIRECT);
    bus.redirect_pc_o    = redirect_pc_q;
    busy_o               = (state_q != ST_IDLE);
  end

  // CSR state, trap entry/exit updates and the latched redirect target.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mscratch_q     <= '0;
      mcounteren_q   <= '0;
      mtvec_base_q   <= BOOT_ADDRESS[XLEN-1:2];
      mtvec_mode_q   <= MTVEC_DIRECT;
      redirect_pc_q  <= '0;
    end else begin
      mip_q <= mip_d;
      if (take_exc || take_irq) begin
        mepc_q         <= (take_exc ? exception_pc_i : retire_pc_i) & ~XLEN'(1);
        mcause_q       <= {take_irq, {(XLEN-7){1'b0}},
                           (take_irq ? arb_code : exception_cause_i)};
        mtval_q        <= take_exc ? exception_tval_i : '0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        redirect_pc_q  <= trap_pc;
      end else if (take_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
        redirect_pc_q  <= mepc_q;
      end else if (csr_we) begin
        case (bus.csr_address_i)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_new[MSTATUS_MIE];
            mstatus_mpie_q <= csr_new[MSTATUS_MPIE];
          end
          CSR_MIE:        mie_q        <= csr_new & MIE_WMASK;
          CSR_MTVEC: begin
            mtvec_base_q <= csr_new[XLEN-1:2];
            mtvec_mode_q <= (VECTORED_EN && csr_new[1:0] == 2'b01) ? MTVEC_VECTORED
                                                                   : MTVEC_DIRECT;
          end
          CSR_MCOUNTEREN: mcounteren_q <= csr_new[31:0];
          CSR_MSCRATCH:   mscratch_q   <= csr_new;
          CSR_MEPC:       mepc_q       <= csr_new & ~XLEN'(1);
          CSR_MCAUSE:     mcause_q     <= csr_new;
          CSR_MTVAL:      mtval_q      <= csr_new;
          default: ;
        endcase
      end
    end
  end

  // Events outside IDLE are dropped by the FSM; flag them as core protocol errors.
  a_event_outside_idle: assert property (
    @(posedge clock_i) disable iff (reset_i)
    (state_q != ST_IDLE) |-> !(exception_i || mret_i || wfi_i)
  );

endmodule

// File: tb/tb_m_trap_unit.sv
// Scoreboard bench for m_trap_unit: expected values are queued as stimulus is
// driven and compared in order as the DUT responds.
module tb_m_trap_unit;
  import m_trap_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception_i = 1'b0;
  logic [5:0]  exception_cause_i = '0;
  logic [63:0] exception_pc_i = '0;
  logic [63:0] exception_tval_i = '0;
  logic        mret_i = 1'b0;
  logic        wfi_i = 1'b0;
  logic        irq_external_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        irq_software_i = 1'b0;
  logic [15:0] irq_local_i = '0;
  logic [63:0] retire_pc_i = 64'h2223;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } exp_t;
  exp_t sb_q[$];

  m_trap_unit_if #(.XLEN(64)) bus ();

  m_trap_unit #(
    .XLEN          (64),
    .NUM_LOCAL_IRQ (16),
    .BOOT_ADDRESS  (64'h8000_0000),
    .VECTORED_EN   (1'b1)
  ) dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .bus               (bus.slave),
    .exception_i       (exception_i),
    .exception_cause_i (exception_cause_i),
    .exception_pc_i    (exception_pc_i),
    .exception_tval_i  (exception_tval_i),
    .mret_i            (mret_i),
    .wfi_i             (wfi_i),
    .irq_external_i    (irq_external_i),
    .irq_timer_i       (irq_timer_i),
    .irq_software_i    (irq_software_i),
    .irq_local_i       (irq_local_i),
    .retire_pc_i       (retire_pc_i),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.value = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.value);
    end
  endtask

  task automatic csr_op(input logic [11:0] a, input csr_command_t c, input logic [63:0] d,
                        output logic [63:0] rd, output logic v, output logic ill);
    @(negedge clk);
    bus.csr_address_i    = a;
    bus.csr_command_i    = c;
    bus.csr_write_data_i = d;
    #1;
    rd  = bus.csr_read_data_o;
    v   = bus.csr_read_data_valid_o;
    ill = bus.csr_illegal_o;
    @(posedge clk);
    #1;
    bus.csr_command_i = CSR_NONE;
  endtask

  // Accepted access: returns old value with valid high.
  task automatic csr_expect(input string tag, input logic [11:0] a, input csr_command_t c,
                            input logic [63:0] d, input logic [63:0] old_val);
    logic [63:0] rd;
    logic v, ill;
    sb_push(tag, old_val);
    sb_push({tag, "_valid"}, 64'd1);
    csr_op(a, c, d, rd, v, ill);
    sb_check(rd);
    sb_check(64'(v));
  endtask

  task automatic csr_expect_illegal(input string tag, input logic [11:0] a, input csr_command_t c);
    logic [63:0] rd;
    logic v, ill;
    sb_push({tag, "_illegal"}, 64'd1);
    sb_push({tag, "_valid"}, 64'd0);
    csr_op(a, c, 64'h1, rd, v, ill);
    sb_check(64'(ill));
    sb_check(64'(v));
  endtask

  // Counts cycles until redirect_valid_o, clearing single-cycle pulses after the first edge.
  task automatic wait_redirect(output int lat);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      exception_i = 1'b0;
      mret_i = 1'b0;
      bus.csr_command_i = CSR_NONE;
      @(negedge clk);
      lat++;
      if (bus.redirect_valid_o) return;
    end
    lat = -1;
  endtask

  task automatic accept_redirect();
    @(negedge clk);
    bus.redirect_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_ready_i = 1'b0;
    sb_push("busy_after_accept", 64'd0);
    @(negedge clk);
    sb_check(64'(busy_o));
  endtask

  initial begin
    int lat;
    logic [63:0] rd;
    logic v, ill;

    bus.csr_address_i    = '0;
    bus.csr_command_i    = CSR_NONE;
    bus.csr_write_data_i = '0;
    bus.redirect_ready_i = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    sb_push("rst_redirect_valid", 64'd0);
    sb_push("rst_redirect_pc", 64'd0);
    sb_push("rst_busy", 64'd0);
    @(negedge clk);
    sb_check(64'(bus.redirect_valid_o));
    sb_check(bus.redirect_pc_o);
    sb_check(64'(busy_o));
    rst = 1'b0;

    csr_expect("mtvec_reset", CSR_MTVEC, CSR_READ_ONLY, '0, 64'h8000_0000);
    csr_expect("mstatus_reset", CSR_MSTATUS, CSR_READ_ONLY, '0, 64'h1800);
    csr_expect("mie_reset", CSR_MIE, CSR_READ_ONLY, '0, 64'h0);

    // Vectored timer interrupt.
    csr_expect("mtvec_wr", CSR_MTVEC, CSR_WRITE_AND_READ, 64'h1001, 64'h8000_0000);
    csr_expect("mtvec_rb", CSR_MTVEC, CSR_READ_ONLY, '0, 64'h1001);
    csr_expect("mie_set_mtie", CSR_MIE, CSR_SET_AND_READ, 64'h80, 64'h0);
    csr_expect("mstatus_set_mie", CSR_MSTATUS, CSR_SET_AND_READ, 64'h8, 64'h1800);
    sb_push("irq_latency", 64'd2);
    sb_push("irq_redirect_pc", 64'h101C);
    @(negedge clk);
    irq_timer_i = 1'b1;
    wait_redirect(lat);
    sb_check(64'(lat));
    sb_check(bus.redirect_pc_o);
    accept_redirect();
    irq_timer_i = 1'b0;
    csr_expect("irq_mcause", CSR_MCAUSE, CSR_READ_ONLY, '0, 64'h8000_0000_0000_0007);
    csr_expect("irq_mstatus", CSR_MSTATUS, CSR_READ_ONLY, '0, 64'h1880);
    csr_expect("irq_mepc", CSR_MEPC, CSR_READ_ONLY, '0, 64'h2222);

    // Exception beats a concurrently pending enabled external interrupt.
    csr_expect("mie_set_meie", CSR_MIE, CSR_SET_AND_READ, 64'h800, 64'h80);
    csr_expect("mstatus_set_mie2", CSR_MSTATUS, CSR_SET_AND_READ, 64'h8, 64'h1880);
    @(negedge clk);
    irq_external_i = 1'b1;
    sb_push("exc_latency", 64'd1);
    sb_push("exc_redirect_pc", 64'h1000);
    @(negedge clk);
    exception_i = 1'b1;
    exception_cause_i = 6'd2;
    exception_pc_i = 64'h4001;
    exception_tval_i = 64'hBAD;
    wait_redirect(lat);
    sb_check(64'(lat));
    sb_check(bus.redirect_pc_o);
    for (int k = 0; k < 3; k++) begin
      sb_push("hold_valid", 64'd1);
      sb_push("hold_pc", 64'h1000);
      @(negedge clk);
      sb_check(64'(bus.redirect_valid_o));
      sb_check(bus.redirect_pc_o);
    end
    accept_redirect();
    irq_external_i = 1'b0;
    csr_expect("exc_mepc", CSR_MEPC, CSR_READ_ONLY, '0, 64'h4000);
    csr_expect("exc_mcause", CSR_MCAUSE, CSR_READ_ONLY, '0, 64'h2);
    csr_expect("exc_mtval", CSR_MTVAL, CSR_READ_ONLY, '0, 64'hBAD);
    csr_expect("exc_mstatus", CSR_MSTATUS, CSR_READ_ONLY, '0, 64'h1880);

    // MRET returns to mepc and restores MIE.
    sb_push("mret_latency", 64'd1);
    sb_push("mret_pc", 64'h4000);
    @(negedge clk);
    mret_i = 1'b1;
    wait_redirect(lat);
    sb_check(64'(lat));
    sb_check(bus.redirect_pc_o);
    accept_redirect();
    csr_expect("mret_mstatus", CSR_MSTATUS, CSR_READ_ONLY, '0, 64'h1888);

    // WFI wakes on an enabled pending interrupt even with MIE clear, no trap.
    csr_expect("mstatus_clr_mie", CSR_MSTATUS, CSR_CLEAR_AND_READ, 64'h8, 64'h1888);
    @(negedge clk);
    wfi_i = 1'b1;
    @(posedge clk);
    #1;
    wfi_i = 1'b0;
    sb_push("wfi_busy", 64'd1);
    sb_push("wfi_no_redirect", 64'd0);
    @(negedge clk);
    sb_check(64'(busy_o));
    sb_check(64'(bus.redirect_valid_o));
    sb_push("wfi_csr_valid", 64'd0);
    csr_op(CSR_MSCRATCH, CSR_READ_ONLY, '0, rd, v, ill);
    sb_check(64'(v));
    @(negedge clk);
    irq_external_i = 1'b1;
    sb_push("wfi_busy_r1", 64'd1);
    sb_push("wfi_busy_r2", 64'd0);
    sb_push("wfi_wake_no_trap", 64'd0);
    @(negedge clk);
    sb_check(64'(busy_o));
    @(negedge clk);
    sb_check(64'(busy_o));
    sb_check(64'(bus.redirect_valid_o));
    irq_external_i = 1'b0;
    csr_expect("wfi_mcause", CSR_MCAUSE, CSR_READ_ONLY, '0, 64'h2);

    // WARL and legality.
    csr_expect_illegal("misa_set", CSR_MISA, CSR_SET_AND_READ);
    csr_expect("misa_rd", CSR_MISA, CSR_READ_ONLY, '0, 64'h8000_0000_0000_0100);
    csr_expect_illegal("unknown_rd", 12'h7C0, CSR_READ_ONLY);
    csr_expect("mie_wr_all", CSR_MIE, CSR_WRITE_AND_READ, '1, 64'h880);
    csr_expect("mie_rb", CSR_MIE, CSR_READ_ONLY, '0, 64'hFFFF_0888);
    csr_expect("mie_wr_zero", CSR_MIE, CSR_WRITE_AND_READ, '0, 64'hFFFF_0888);
    csr_expect("mepc_wr", CSR_MEPC, CSR_WRITE_AND_READ, 64'h1235, 64'h4000);
    csr_expect("mepc_rb", CSR_MEPC, CSR_READ_ONLY, '0, 64'h1234);
    csr_expect("mtvec_wr3", CSR_MTVEC, CSR_WRITE_AND_READ, 64'h2003, 64'h1001);
    csr_expect("mtvec_rb3", CSR_MTVEC, CSR_READ_ONLY, '0, 64'h2000);

    // MRET wins over a same-cycle CSR write, which is dropped.
    sb_push("mret2_latency", 64'd1);
    sb_push("mret2_pc", 64'h1234);
    @(negedge clk);
    mret_i = 1'b1;
    bus.csr_address_i = CSR_MSCRATCH;
    bus.csr_command_i = CSR_WRITE_AND_READ;
    bus.csr_write_data_i = 64'h55;
    wait_redirect(lat);
    sb_check(64'(lat));
    sb_check(bus.redirect_pc_o);
    accept_redirect();
    csr_expect("mscratch_dropped", CSR_MSCRATCH, CSR_READ_ONLY, '0, 64'h0);

    // Reset during REDIRECT aborts the request.
    sb_push("pre_reset_latency", 64'd1);
    @(negedge clk);
    exception_i = 1'b1;
    exception_cause_i = 6'd0;
    exception_pc_i = 64'h8;
    wait_redirect(lat);
    sb_check(64'(lat));
    rst = 1'b1;
    sb_push("reset_abort_valid", 64'd0);
    sb_push("reset_abort_busy", 64'd0);
    @(negedge clk);
    sb_check(64'(bus.redirect_valid_o));
    sb_check(64'(busy_o));
    rst = 1'b0;
    csr_expect("mtvec_rereset", CSR_MTVEC, CSR_READ_ONLY, '0, 64'h8000_0000);

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
